mem_loader: RTL and testbench

//  Host-side initiator for the CPU top's override memory port (override_memwrite/memread/rwaddr/rwdata, memdata).

---
 rtl/mem_loader_pkg.sv | 26 ++
 rtl/mem_loader_word_packer.sv | 50 +++++
 rtl/mem_loader.sv | 151 +++++++++++++++
 tb/tb_mem_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the host-side memory loader: command bytes and FSM encoding.
package mem_loader_pkg;

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_READ = 8'h5A;
  localparam logic [7:0] CMD_RUN  = 8'hC3;

  localparam int BYTE_IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    LD_BYTE,
    LD_WRITE,
    RB_READ,
    RB_WAIT,
    RB_SEND
  } state_e;

  // States in which a host byte may be taken.
  function automatic logic takes_input(input state_e s);
    return (s == IDLE) || (s == CNT_LO) || (s == CNT_HI) || (s == LD_BYTE);
  endfunction

endpackage

// File: rtl/mem_loader_word_packer.sv
// Byte<->word shift register: assembles little-endian words from bytes and serialises words back to bytes.
module word_packer
  import mem_loader_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 put,
  input  logic                 load,
  input  logic                 advance,
  input  logic [7:0]           byte_in,
  input  logic [BIT_WIDTH-1:0] word_in,
  output logic [BIT_WIDTH-1:0] merged,
  output logic [7:0]           byte_out,
  output logic                 last
);

  logic [BIT_WIDTH-1:0]  word;
  logic [BYTE_IDX_W-1:0] idx;

  // merged is the word as it will look once byte_in lands at the current index
  always_comb begin
    merged = word;
    merged[{idx, 3'b000} +: 8] = byte_in;
  end

  assign byte_out = word[{idx, 3'b000} +: 8];
  assign last     = (idx == {BYTE_IDX_W{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clear || load) begin
      idx <= '0;
    end else if (put || advance) begin
      idx <= idx + BYTE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      word <= word_in;
    end else if (put) begin
      word <= merged;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Host-side initiator for the CPU override memory port: framed LOAD / READBACK / RUN commands from a byte stream.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int                   BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] ADDR_BASE = '0,
  parameter logic [BIT_WIDTH-1:0] ADDR_INC  = 1,
  parameter int                   RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 override_memwrite,
  output logic                 override_memread,
  output logic [BIT_WIDTH-1:0] override_rwaddr,
  output logic [BIT_WIDTH-1:0] override_rwdata,
  input  logic [BIT_WIDTH-1:0] memdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int WAIT_W = $clog2(RD_LAT) + 1;

  state_e               state;
  state_e               nxt;
  logic                 is_read;
  logic [15:0]          cnt;
  logic [15:0]          widx;
  logic [BIT_WIDTH-1:0] next_addr;
  logic [WAIT_W-1:0]    wait_cnt;

  logic accept_in, accept_out, last_word, wait_done, frame_cmd, cmd_accept;
  logic pk_clear, pk_put, pk_load, pk_advance, pk_last;
  logic [BIT_WIDTH-1:0] pk_merged;
  logic [7:0]           pk_byte;

  assign accept_in  = in_valid && in_ready;
  assign accept_out = out_valid && out_ready;
  assign cmd_accept = (state == IDLE) && accept_in;
  assign frame_cmd  = (in_data == CMD_LOAD) || (in_data == CMD_READ);
  assign last_word  = (widx + 16'd1) == cnt;
  assign wait_done  = (wait_cnt == WAIT_W'(RD_LAT - 1));

  assign pk_clear   = cmd_accept;
  assign pk_put     = (state == LD_BYTE) && accept_in;
  assign pk_load    = (state == RB_WAIT) && wait_done;
  assign pk_advance = (state == RB_SEND) && accept_out;

  // out_data is forced to zero whenever no byte is offered so it reads 0 out of reset
  assign out_data = out_valid ? pk_byte : 8'h00;

  word_packer #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (pk_clear),
    .put     (pk_put),
    .load    (pk_load),
    .advance (pk_advance),
    .byte_in (in_data),
    .word_in (memdata),
    .merged  (pk_merged),
    .byte_out(pk_byte),
    .last    (pk_last)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (accept_in && frame_cmd) nxt = CNT_LO;
      CNT_LO:   if (accept_in) nxt = CNT_HI;
      CNT_HI: begin
        if (accept_in) begin
          if ({in_data, cnt[7:0]} == 16'd0) nxt = IDLE;
          else if (is_read)                 nxt = RB_READ;
          else                              nxt = LD_BYTE;
        end
      end
      LD_BYTE:  if (accept_in && pk_last) nxt = LD_WRITE;
      LD_WRITE: nxt = last_word ? IDLE : LD_BYTE;
      RB_READ:  nxt = RB_WAIT;
      RB_WAIT:  if (wait_done) nxt = RB_SEND;
      RB_SEND:  if (accept_out && pk_last) nxt = last_word ? IDLE : RB_READ;
      default:  nxt = IDLE;
    endcase
  end

  // All outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      in_ready          <= 1'b0;
      out_valid         <= 1'b0;
      override_memwrite <= 1'b0;
      override_memread  <= 1'b0;
      override_rwaddr   <= '0;
      override_rwdata   <= '0;
      cpu_hold          <= 1'b1;
      busy              <= 1'b0;
      cmd_err           <= 1'b0;
      is_read           <= 1'b0;
      cnt               <= '0;
      widx              <= '0;
      next_addr         <= ADDR_BASE;
      wait_cnt          <= '0;
    end else begin
      state             <= nxt;
      in_ready          <= takes_input(nxt);
      busy              <= (nxt != IDLE);
      out_valid         <= (nxt == RB_SEND);
      override_memwrite <= (nxt == LD_WRITE);
      override_memread  <= (nxt == RB_READ) || (nxt == RB_WAIT);
      cmd_err           <= cmd_accept && !frame_cmd && (in_data != CMD_RUN);
      wait_cnt          <= (state == RB_WAIT) ? wait_cnt + WAIT_W'(1) : '0;

      if (cmd_accept) begin
        if (frame_cmd) begin
          cpu_hold  <= 1'b1;
          is_read   <= (in_data == CMD_READ);
          widx      <= '0;
          next_addr <= ADDR_BASE;
        end else if (in_data == CMD_RUN) begin
          cpu_hold <= 1'b0;
        end
      end

      if ((state == CNT_LO) && accept_in) cnt[7:0]  <= in_data;
      if ((state == CNT_HI) && accept_in) cnt[15:8] <= in_data;

      if (nxt == LD_WRITE) override_rwdata <= pk_merged;

      // Address is latched on entry to each word's access; wraps modulo 2^BIT_WIDTH
      if ((nxt == LD_WRITE) || ((nxt == RB_READ) && (state != RB_READ))) begin
        override_rwaddr <= next_addr;
        next_addr       <= next_addr + ADDR_INC;
      end

      if ((state == LD_WRITE) || ((state == RB_SEND) && (nxt != RB_SEND))) begin
        widx <= widx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: load, readback, run, unknown command, empty frame, reset abort, address wrap.
module tb_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        tgt;
  logic        in_valid_a, in_valid_b, in_ready_a, in_ready_b, rdy;

  assign in_valid_a = in_valid && !tgt;
  assign in_valid_b = in_valid && tgt;
  assign rdy        = tgt ? in_ready_b : in_ready_a;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        memwrite, memread;
  logic [31:0] rwaddr, rwdata, memdata;
  logic        cpu_hold, busy, cmd_err;

  logic [7:0]  w_out_data;
  logic        w_out_valid, w_memwrite, w_memread;
  logic [31:0] w_rwaddr, w_rwdata;
  logic        w_cpu_hold, w_busy, w_cmd_err;

  mem_loader dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .override_memwrite(memwrite), .override_memread(memread),
    .override_rwaddr(rwaddr), .override_rwdata(rwdata), .memdata(memdata),
    .cpu_hold(cpu_hold), .busy(busy), .cmd_err(cmd_err)
  );

  mem_loader #(.ADDR_BASE(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(1'b1),
    .override_memwrite(w_memwrite), .override_memread(w_memread),
    .override_rwaddr(w_rwaddr), .override_rwdata(w_rwdata), .memdata(32'h0),
    .cpu_hold(w_cpu_hold), .busy(w_busy), .cmd_err(w_cmd_err)
  );

  // Memory model with a two-cycle read pipeline; junk is returned when memread is low
  logic [31:0] mem [16];
  logic [31:0] pipe1;
  always @(posedge clk) begin
    if (memwrite) mem[rwaddr[3:0]] <= rwdata;
    pipe1   <= memread ? mem[rwaddr[3:0]] : 32'hDEAD_BEEF;
    memdata <= pipe1;
  end

  logic rand_en = 1'b0;
  logic ready_fix = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  int checks = 0, errors = 0;
  int wr_cnt = 0, rd_cycles = 0, both_cnt = 0, err_cnt = 0, wr_rdy_viol = 0, stab_viol = 0;
  int w_wr_cnt = 0, w_rd_cycles = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], w_addr_q[$], w_data_q[$];
  logic [7:0]  out_q[$];
  logic        hold_prev = 1'b0;
  logic [7:0]  held = 8'h00;

  always @(negedge clk) begin
    if (memwrite) begin
      wr_cnt++;
      wr_addr_q.push_back(rwaddr);
      wr_data_q.push_back(rwdata);
      if (in_ready_a) wr_rdy_viol++;
    end
    if (memread) rd_cycles++;
    if (memwrite && memread) both_cnt++;
    if (cmd_err) err_cnt++;
    if (hold_prev && (!out_valid || out_data !== held)) stab_viol++;
    if (out_valid && out_ready) out_q.push_back(out_data);
    hold_prev = out_valid && !out_ready;
    held      = out_data;
    if (w_memwrite) begin
      w_wr_cnt++;
      w_addr_q.push_back(w_rwaddr);
      w_data_q.push_back(w_rwdata);
    end
    if (w_memread) w_rd_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_timeout", 32'(t < 200), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int t = 0;
    while (out_q.size() < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("readback_timeout", 32'(t < limit), 32'd1);
  endtask

  logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] load1 [11] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD};
  int base_wr, base_rd;

  initial begin
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    tgt      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_memwrite", 32'(memwrite), 32'd0);
    chk("rst_memread", 32'(memread), 32'd0);
    chk("rst_rwaddr", rwaddr, 32'd0);
    chk("rst_rwdata", rwdata, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 32'(in_ready_a), 32'd1);

    // LOAD two words
    send_byte(load1[0]);
    chk("load_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 11; i++) send_byte(load1[i]);
    repeat (4) @(negedge clk);
    chk("load_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("load_addr0", wr_addr_q[0], 32'h0000_0000);
    chk("load_data0", wr_data_q[0], 32'h4433_2211);
    chk("load_addr1", wr_addr_q[1], 32'h0000_0001);
    chk("load_data1", wr_data_q[1], 32'hDDCC_BBAA);
    chk("load_ready_in_write", 32'(wr_rdy_viol), 32'd0);
    chk("load_busy_end", 32'(busy), 32'd0);
    chk("load_hold_end", 32'(cpu_hold), 32'd1);

    // READBACK with out_ready held high
    ready_fix = 1'b1;
    base_wr   = wr_cnt;
    send_byte(8'h5A);
    send_byte(8'h02);
    send_byte(8'h00);
    wait_bytes(8, 300);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("rb1_byte%0d", i), 32'(out_q[i]), 32'(exp_b[i]));
    chk("rb1_count", 32'(out_q.size()), 32'd8);
    chk("rb1_memread_seen", 32'(rd_cycles > 0), 32'd1);
    chk("rb1_no_write", 32'(wr_cnt), 32'(base_wr));
    chk("rb1_busy_end", 32'(busy), 32'd0);

    // RUN then an unknown command
    send_byte(8'hC3);
    chk("run_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("run_busy", 32'(busy), 32'd0);
    base_wr = wr_cnt;
    base_rd = rd_cycles;
    send_byte(8'h7E);
    chk("bad_cmd_err", 32'(cmd_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("bad_err_pulses", 32'(err_cnt), 32'd1);
    chk("bad_no_write", 32'(wr_cnt), 32'(base_wr));
    chk("bad_no_read", 32'(rd_cycles), 32'(base_rd));
    chk("bad_hold_stays", 32'(cpu_hold), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);

    // Empty LOAD frame
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("n0_no_write", 32'(wr_cnt), 32'(base_wr));
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_cpu_hold", 32'(cpu_hold), 32'd1);

    // READBACK with random back-pressure
    ready_fix = 1'b0;
    rand_en   = 1'b1;
    send_byte(8'h5A);
    send_byte(8'h02);
    send_byte(8'h00);
    wait_bytes(16, 2000);
    rand_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("rb2_byte%0d", i), 32'(out_q[8 + i]), 32'(exp_b[i]));
    chk("rb2_count", 32'(out_q.size()), 32'd16);
    chk("rb_out_stable", 32'(stab_viol), 32'd0);
    chk("never_both_strobes", 32'(both_cnt), 32'd0);

    // Reset in the middle of a word
    base_wr = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt), 32'(base_wr));
    chk("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("abort_in_ready", 32'(in_ready_a), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    repeat (4) @(negedge clk);
    chk("fresh_wr_cnt", 32'(wr_cnt), 32'(base_wr + 1));
    chk("fresh_addr", wr_addr_q[base_wr], 32'h0000_0000);
    chk("fresh_data", wr_data_q[base_wr], 32'hEFBE_ADDE);

    // Address wrap on the instance based at FFFF_FFFF
    tgt = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    repeat (4) @(negedge clk);
    tgt = 1'b0;
    chk("wrap_wr_cnt", 32'(w_wr_cnt), 32'd2);
    chk("wrap_addr0", w_addr_q[0], 32'hFFFF_FFFF);
    chk("wrap_addr1", w_addr_q[1], 32'h0000_0000);
    chk("wrap_data0", w_data_q[0], 32'h0403_0201);
    chk("wrap_data1", w_data_q[1], 32'h0807_0605);
    chk("wrap_no_read", 32'(w_rd_cycles), 32'd0);
    chk("wrap_cmd_err", 32'(w_cmd_err), 32'd0);
    chk("wrap_busy", 32'(w_busy), 32'd0);
    chk("wrap_cpu_hold", 32'(w_cpu_hold), 32'd1);
    chk("wrap_out_idle", {23'd0, w_out_valid, w_out_data}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
